reg_read_sequencer: RTL and testbench

- Consumes the 2-bit read-select code produced by the control unit's register-read decoder (00 none, 01 R3, 10 R2, 11 both) plus the R2/R3 source addresses of one instruction.
- Fetches the requested operands from a single-read-port, 1-cycle-latency register file, one read at a time.
- Presents both operands to the datapath with a valid/ready handshake.
- Sits between decode and the vector/scalar operand latch stage.

---
 rtl/reg_read_sequencer.sv | 105 ++++++++++
 tb/tb_reg_read_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/reg_read_sequencer.sv
// Operand fetch sequencer: turns a decoded read-select code into one or two
// single-port register file reads and hands both operands over valid/ready.
module reg_read_sequencer #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_rsel,
  input  logic [ADDR_W-1:0] in_r2_addr,
  input  logic [ADDR_W-1:0] in_r3_addr,
  output logic              rf_ren,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_op2,
  output logic [DATA_W-1:0] out_op3
);

  typedef enum logic [2:0] {IDLE, ISSUE_R2, ISSUE_R3, CAPTURE, DONE} state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_R2, TAG_R3} tag_t;

  state_t            state;
  tag_t              pend;
  logic [1:0]        rsel_q;
  logic [ADDR_W-1:0] r3_q;

  assign in_ready = (state == IDLE) && !rst;

  // rf_ren/rf_addr are registered one state ahead so they are high exactly
  // during the ISSUE_* cycles; the tag then marks the following cycle's rdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pend      <= TAG_NONE;
      rsel_q    <= '0;
      r3_q      <= '0;
      rf_ren    <= 1'b0;
      rf_addr   <= '0;
      out_valid <= 1'b0;
      out_op2   <= '0;
      out_op3   <= '0;
    end else begin
      case (pend)
        TAG_R2:  out_op2 <= rf_rdata;
        TAG_R3:  out_op3 <= rf_rdata;
        default: ;
      endcase
      pend    <= TAG_NONE;
      rf_ren  <= 1'b0;
      rf_addr <= '0;
      case (state)
        IDLE: if (in_valid) begin
          rsel_q  <= in_rsel;
          r3_q    <= in_r3_addr;
          out_op2 <= '0;
          out_op3 <= '0;
          case (in_rsel)
            2'b11, 2'b10: begin
              state   <= ISSUE_R2;
              rf_ren  <= 1'b1;
              rf_addr <= in_r2_addr;
            end
            2'b01: begin
              state   <= ISSUE_R3;
              rf_ren  <= 1'b1;
              rf_addr <= in_r3_addr;
            end
            default: begin
              state     <= DONE;
              out_valid <= 1'b1;
            end
          endcase
        end
        ISSUE_R2: begin
          pend <= TAG_R2;
          if (rsel_q == 2'b11) begin
            state   <= ISSUE_R3;
            rf_ren  <= 1'b1;
            rf_addr <= r3_q;
          end else begin
            state <= CAPTURE;
          end
        end
        ISSUE_R3: begin
          pend  <= TAG_R3;
          state <= CAPTURE;
        end
        CAPTURE: begin
          state     <= DONE;
          out_valid <= 1'b1;
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_read_sequencer.sv
// Scoreboard bench for reg_read_sequencer: expected reads and operands are
// queued at issue time and a negedge monitor pops and compares them.
module tb_reg_read_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_rsel;
  logic [4:0]  in_r2_addr;
  logic [4:0]  in_r3_addr;
  logic        rf_ren;
  logic [4:0]  rf_addr;
  logic [31:0] rf_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_op2;
  logic [31:0] out_op3;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [32];
  logic [4:0]  addr_q [$];
  logic [63:0] op_q [$];

  reg_read_sequencer #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_rsel(in_rsel),
    .in_r2_addr(in_r2_addr), .in_r3_addr(in_r3_addr),
    .rf_ren(rf_ren), .rf_addr(rf_addr), .rf_rdata(rf_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op2(out_op2), .out_op3(out_op3)
  );

  always #5 clk = ~clk;

  // 1-cycle-latency register file; junk on idle cycles must never be captured.
  always @(posedge clk) rf_rdata <= rf_ren ? mem[rf_addr] : $urandom;

  always @(negedge clk) begin
    if (rf_ren === 1'b1) begin
      logic [4:0] ea;
      checks++;
      if (addr_q.size() == 0) begin
        errors++;
        $display("FAIL rf_read unexpected read got=%0d", rf_addr);
      end else begin
        ea = addr_q.pop_front();
        if (rf_addr !== ea) begin
          errors++;
          $display("FAIL rf_addr got=%0d exp=%0d", rf_addr, ea);
        end
      end
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      logic [63:0] e;
      checks++;
      if (op_q.size() == 0) begin
        errors++;
        $display("FAIL out_xfer unexpected op2=%h op3=%h", out_op2, out_op3);
      end else begin
        e = op_q.pop_front();
        if (out_op2 !== e[63:32] || out_op3 !== e[31:0]) begin
          errors++;
          $display("FAIL operands got=%h/%h exp=%h/%h", out_op2, out_op3, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 once out_valid is seen.
  task automatic send(input logic [1:0] rs, input logic [4:0] a2, input logic [4:0] a3,
                      input int lat, input string nm);
    int n;
    in_rsel = rs; in_r2_addr = a2; in_r3_addr = a3; in_valid = 1'b1;
    chk({nm, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_r2_addr = 5'd31; in_r3_addr = 5'd30; in_rsel = 2'($urandom);
    n = 1;
    while (out_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_latency"}, n, lat);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + i;
    mem[3] = 32'h1111_1111;
    mem[7] = 32'h2222_2222;
    rst = 1'b1; in_valid = 1'b0; in_rsel = 2'b00; in_r2_addr = '0; in_r3_addr = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_rf_ren", {31'b0, rf_ren}, 32'd0);
    chk("rst_rf_addr", {27'b0, rf_addr}, 32'd0);
    chk("rst_op2", out_op2, 32'd0);
    chk("rst_op3", out_op3, 32'd0);
    rst = 1'b0;
    step();

    addr_q.push_back(5'd3); addr_q.push_back(5'd7);
    op_q.push_back({32'h1111_1111, 32'h2222_2222});
    send(2'b11, 5'd3, 5'd7, 4, "both");
    step();

    addr_q.push_back(5'd5);
    op_q.push_back({32'hA000_0005, 32'h0});
    send(2'b10, 5'd5, 5'd6, 3, "r2_only");
    step();

    addr_q.push_back(5'd9);
    op_q.push_back({32'h0, 32'hA000_0009});
    send(2'b01, 5'd8, 5'd9, 3, "r3_only");
    step();

    op_q.push_back({32'h0, 32'h0});
    send(2'b00, 5'd1, 5'd2, 1, "none");
    step();

    addr_q.push_back(5'd4); addr_q.push_back(5'd4);
    op_q.push_back({32'hA000_0004, 32'hA000_0004});
    send(2'b11, 5'd4, 5'd4, 4, "same_addr");
    step();

    // Back-pressure: hold DONE for 5 cycles, then release and re-issue at once.
    out_ready = 1'b0;
    addr_q.push_back(5'd3); addr_q.push_back(5'd7);
    op_q.push_back({32'h1111_1111, 32'h2222_2222});
    send(2'b11, 5'd3, 5'd7, 4, "bp");
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_op2", out_op2, 32'h1111_1111);
      chk("bp_op3", out_op3, 32'h2222_2222);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_release_valid", {31'b0, out_valid}, 32'd0);
    addr_q.push_back(5'd5);
    op_q.push_back({32'hA000_0005, 32'h0});
    send(2'b10, 5'd5, 5'd0, 3, "after_bp");
    step();

    // Reset during ISSUE_R3 of a two-operand request.
    addr_q.push_back(5'd3); addr_q.push_back(5'd7);
    in_rsel = 2'b11; in_r2_addr = 5'd3; in_r3_addr = 5'd7; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("rst_mid_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_mid_op2", out_op2, 32'd0);
    chk("rst_mid_op3", out_op3, 32'd0);
    chk("rst_mid_rf_ren", {31'b0, rf_ren}, 32'd0);
    repeat (3) begin
      step();
      chk("rst_mid_no_valid", {31'b0, out_valid}, 32'd0);
    end
    addr_q.push_back(5'd5);
    op_q.push_back({32'hA000_0005, 32'h0});
    send(2'b10, 5'd5, 5'd2, 3, "after_rst");
    repeat (3) step();

    chk("addr_q_drained", addr_q.size(), 32'd0);
    chk("op_q_drained", op_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
